// File: rtl/score_bcd_counter_if.sv
// Game-logic to score-keeper bundle: round events in, BCD display digits out.
// The master drives the events; the score keeper is the slave.
interface score_bcd_counter_if;
  logic       game_start;
  logic       pass_in;
  logic       game_over;
  logic       show_best;
  logic [3:0] ge;
  logic [3:0] shi;
  logic [3:0] bai;
  logic       new_record;
  logic       saturated;
  logic       playing;

  modport master (
    output game_start,
    output pass_in,
    output game_over,
    output show_best,
    input  ge,
    input  shi,
    input  bai,
    input  new_record,
    input  saturated,
    input  playing
  );

  modport slave (
    input  game_start,
    input  pass_in,
    input  game_over,
    input  show_best,
    output ge,
    output shi,
    output bai,
    output new_record,
    output saturated,
    output playing
  );
endinterface

// File: rtl/score_bcd_counter.sv
// Saturating BCD score counter with session best and display select.
// Feeds three registered BCD digits to the 7-segment driver.
module score_bcd_counter #(
  parameter logic [11:0] MAX_SCORE = 12'h999,
  parameter int          EDGE_MODE = 1
) (
  input logic               dclk,
  input logic               rst,
  score_bcd_counter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PLAY   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] OVER   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [11:0] cur_score;
  logic [11:0] cur_n;
  logic [11:0] best_score;
  logic [11:0] best_n;
  logic        nr;
  logic        nr_n;
  logic        pass_q;
  logic        evt;
  logic        cnt_en;
  logic [11:0] disp;

  // Ripple carry ge -> shi -> bai, one decimal digit at a time.
  function automatic logic [11:0] bcd_inc(
    input logic [11:0] v
  );
    logic [3:0] g;
    logic [3:0] s;
    logic [3:0] b;
    g = v[3:0];
    s = v[7:4];
    b = v[11:8];
    if (g != 4'd9) begin
      g = g + 4'd1;
    end else if (s != 4'd9) begin
      g = 4'd0;
      s = s + 4'd1;
    end else begin
      g = 4'd0;
      s = 4'd0;
      b = b + 4'd1;
    end
    return {b, s, g};
  endfunction

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign evt = bus.pass_in & ~pass_q;
    end else begin : g_level
      assign evt = bus.pass_in;
    end
  endgenerate

  assign cnt_en = (state == PLAY)
                & ~bus.game_start
                & evt
                & (cur_score != MAX_SCORE);

  always_comb begin
    state_n = state;
    cur_n   = cur_score;
    best_n  = best_score;
    nr_n    = nr;
    unique case (1'b1)
      (state == IDLE),
      (state == OVER): begin
        if (bus.game_start) begin
          state_n = PLAY;
          cur_n   = '0;
          nr_n    = 1'b0;
        end
      end
      (state == PLAY): begin
        if (bus.game_start) begin
          cur_n = '0;
          nr_n  = 1'b0;
        end else begin
          if (cnt_en) cur_n = bcd_inc(cur_score);
          if (bus.game_over) state_n = UPDATE;
        end
      end
      (state == UPDATE): begin
        state_n = OVER;
        // Packed BCD orders the same as plain unsigned; ties are not records.
        if (cur_score > best_score) begin
          best_n = cur_score;
          nr_n   = 1'b1;
        end else begin
          nr_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (!rst) begin
      state          <= IDLE;
      cur_score      <= '0;
      best_score     <= '0;
      nr             <= 1'b0;
      pass_q         <= 1'b0;
      disp           <= '0;
      bus.saturated  <= 1'b0;
      bus.playing    <= 1'b0;
    end else begin
      state          <= state_n;
      cur_score      <= cur_n;
      best_score     <= best_n;
      nr             <= nr_n;
      pass_q         <= bus.pass_in;
      disp           <= bus.show_best ? best_score : cur_score;
      bus.saturated  <= (cur_n == MAX_SCORE);
      bus.playing    <= (state_n == PLAY);
    end
  end

  assign bus.bai        = disp[11:8];
  assign bus.shi        = disp[7:4];
  assign bus.ge         = disp[3:0];
  assign bus.new_record = nr;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed bench for score_bcd_counter: three instances share stimulus,
// covering edge/level counting and a reduced saturation limit.
module tb_score_bcd_counter;

  logic dclk = 1'b0;
  logic rst  = 1'b0;
  logic game_start = 1'b0;
  logic pass_in    = 1'b0;
  logic game_over  = 1'b0;
  logic show_best  = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 dclk = ~dclk;

  score_bcd_counter_if ifa ();
  score_bcd_counter_if ifb ();
  score_bcd_counter_if ifc ();

  assign ifa.game_start = game_start;
  assign ifa.pass_in    = pass_in;
  assign ifa.game_over  = game_over;
  assign ifa.show_best  = show_best;
  assign ifb.game_start = game_start;
  assign ifb.pass_in    = pass_in;
  assign ifb.game_over  = game_over;
  assign ifb.show_best  = show_best;
  assign ifc.game_start = game_start;
  assign ifc.pass_in    = pass_in;
  assign ifc.game_over  = game_over;
  assign ifc.show_best  = show_best;

  score_bcd_counter #(.MAX_SCORE(12'h999), .EDGE_MODE(1)) dut_a (
    .dclk(dclk), .rst(rst), .bus(ifa.slave));
  score_bcd_counter #(.MAX_SCORE(12'h999), .EDGE_MODE(0)) dut_b (
    .dclk(dclk), .rst(rst), .bus(ifb.slave));
  score_bcd_counter #(.MAX_SCORE(12'h105), .EDGE_MODE(1)) dut_c (
    .dclk(dclk), .rst(rst), .bus(ifc.slave));

  wire [11:0] da = {ifa.bai, ifa.shi, ifa.ge};
  wire [11:0] db = {ifb.bai, ifb.shi, ifb.ge};
  wire [11:0] dc = {ifc.bai, ifc.shi, ifc.ge};

  task automatic cyc();
    @(posedge dclk);
    #1;
  endtask

  task automatic pulse();
    pass_in = 1'b1;
    cyc();
    pass_in = 1'b0;
    cyc();
  endtask

  task automatic start();
    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic play_round(input int n);
    start();
    for (int i = 0; i < n; i++) pulse();
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (da !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_disp got %h want 000", da);
    end
    n_chk++;
    if ({ifa.new_record, ifa.saturated, ifa.playing} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {ifa.new_record, ifa.saturated, ifa.playing});
    end
  endtask

  task automatic test_count();
    start();
    n_chk++;
    if (ifa.playing !== 1'b1) begin
      n_fail++;
      $display("FAIL start_playing got %b want 1", ifa.playing);
    end
    pass_in = 1'b1;
    cyc();
    n_chk++;
    if (da !== 12'h000) begin
      n_fail++;
      $display("FAIL count_lag got %h want 000", da);
    end
    pass_in = 1'b0;
    cyc();
    n_chk++;
    if (da !== 12'h001) begin
      n_fail++;
      $display("FAIL count_first got %h want 001", da);
    end
    for (int i = 0; i < 11; i++) pulse();
    n_chk++;
    if (da !== 12'h012) begin
      n_fail++;
      $display("FAIL count_12 got %h want 012", da);
    end
  endtask

  task automatic test_hold();
    start();
    pass_in = 1'b1;
    repeat (5) cyc();
    pass_in = 1'b0;
    cyc();
    cyc();
    n_chk++;
    if (da !== 12'h001) begin
      n_fail++;
      $display("FAIL hold_edge got %h want 001", da);
    end
    n_chk++;
    if (db !== 12'h005) begin
      n_fail++;
      $display("FAIL hold_level got %h want 005", db);
    end
    pass_in = 1'b1;
    cyc();
    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
    repeat (3) cyc();
    pass_in = 1'b0;
    cyc();
    cyc();
    n_chk++;
    if (da !== 12'h000) begin
      n_fail++;
      $display("FAIL held_entry_edge got %h want 000", da);
    end
    n_chk++;
    if (db !== 12'h003) begin
      n_fail++;
      $display("FAIL held_entry_level got %h want 003", db);
    end
  endtask

  task automatic test_carry_sat();
    start();
    for (int i = 0; i < 99; i++) pulse();
    n_chk++;
    if (da !== 12'h099) begin
      n_fail++;
      $display("FAIL pre_carry got %h want 099", da);
    end
    pulse();
    n_chk++;
    if (da !== 12'h100) begin
      n_fail++;
      $display("FAIL double_carry got %h want 100", da);
    end
    for (int i = 0; i < 4; i++) pulse();
    n_chk++;
    if (ifc.saturated !== 1'b0 || dc !== 12'h104) begin
      n_fail++;
      $display("FAIL sat_104 got %h/%b want 104/0", dc, ifc.saturated);
    end
    pulse();
    n_chk++;
    if (ifc.saturated !== 1'b1 || dc !== 12'h105) begin
      n_fail++;
      $display("FAIL sat_105 got %h/%b want 105/1", dc, ifc.saturated);
    end
    for (int i = 0; i < 3; i++) pulse();
    n_chk++;
    if (ifc.saturated !== 1'b1 || dc !== 12'h105) begin
      n_fail++;
      $display("FAIL sat_hold got %h/%b want 105/1", dc, ifc.saturated);
    end
    n_chk++;
    if (ifa.saturated !== 1'b0 || da !== 12'h108) begin
      n_fail++;
      $display("FAIL nosat_108 got %h/%b want 108/0", da, ifa.saturated);
    end
  endtask

  task automatic test_record();
    do_reset();
    play_round(7);
    n_chk++;
    if (ifa.new_record !== 1'b1) begin
      n_fail++;
      $display("FAIL rec1_flag got %b want 1", ifa.new_record);
    end
    show_best = 1'b1;
    cyc();
    n_chk++;
    if (da !== 12'h007) begin
      n_fail++;
      $display("FAIL rec1_best got %h want 007", da);
    end
    show_best = 1'b0;
    play_round(7);
    n_chk++;
    if (ifa.new_record !== 1'b0) begin
      n_fail++;
      $display("FAIL rec2_tie got %b want 0", ifa.new_record);
    end
    show_best = 1'b1;
    cyc();
    n_chk++;
    if (da !== 12'h007) begin
      n_fail++;
      $display("FAIL rec2_best got %h want 007", da);
    end
    show_best = 1'b0;
    play_round(8);
    show_best = 1'b1;
    cyc();
    n_chk++;
    if (ifa.new_record !== 1'b1 || da !== 12'h008) begin
      n_fail++;
      $display("FAIL rec3 got %b/%h want 1/008", ifa.new_record, da);
    end
    show_best = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    start();
    for (int i = 0; i < 4; i++) pulse();
    pass_in   = 1'b1;
    game_over = 1'b1;
    cyc();
    pass_in   = 1'b0;
    game_over = 1'b0;
    cyc();
    cyc();
    n_chk++;
    if (da !== 12'h005 || ifa.new_record !== 1'b1) begin
      n_fail++;
      $display("FAIL evt_over got %h/%b want 005/1", da, ifa.new_record);
    end
    show_best = 1'b1;
    cyc();
    n_chk++;
    if (da !== 12'h005) begin
      n_fail++;
      $display("FAIL evt_over_best got %h want 005", da);
    end
    show_best = 1'b0;
    start();
    for (int i = 0; i < 3; i++) pulse();
    game_start = 1'b1;
    game_over  = 1'b1;
    cyc();
    game_start = 1'b0;
    game_over  = 1'b0;
    cyc();
    cyc();
    n_chk++;
    if (da !== 12'h000 || ifa.playing !== 1'b1) begin
      n_fail++;
      $display("FAIL start_over got %h/%b want 000/1", da, ifa.playing);
    end
    show_best = 1'b1;
    cyc();
    n_chk++;
    if (da !== 12'h005) begin
      n_fail++;
      $display("FAIL start_over_best got %h want 005", da);
    end
    show_best = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    play_round(40);
    start();
    for (int i = 0; i < 23; i++) pulse();
    n_chk++;
    if (da !== 12'h023) begin
      n_fail++;
      $display("FAIL mid_pre got %h want 023", da);
    end
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    n_chk++;
    if (da !== 12'h000 ||
        {ifa.new_record, ifa.saturated, ifa.playing} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_rst got %h/%b want 000/000", da,
               {ifa.new_record, ifa.saturated, ifa.playing});
    end
    show_best = 1'b1;
    cyc();
    n_chk++;
    if (da !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_best got %h want 000", da);
    end
    show_best = 1'b0;
    pulse();
    n_chk++;
    if (da !== 12'h000 || ifa.playing !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore got %h/%b want 000/0", da, ifa.playing);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_hold();
    test_carry_sat();
    test_record();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
